// File: rtl/video_pkg.sv
// Shared types and constant helpers for the raster generator: pattern
// select, FSM state, timing bundle and the colour-bar table.
package video_pkg;

  typedef enum logic [1:0] {PAT_SOLID, PAT_BARS, PAT_CHECK, PAT_RAMP} pattern_e;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  typedef struct packed {
    logic [31:0] hdisp;
    logic [31:0] hfp;
    logic [31:0] hpulse;
    logic [31:0] hbp;
    logic [31:0] vdisp;
    logic [31:0] vfp;
    logic [31:0] vpulse;
    logic [31:0] vbp;
  } timing_t;

  function automatic int unsigned h_total(timing_t t);
    return t.hdisp + t.hfp + t.hpulse + t.hbp;
  endfunction

  function automatic int unsigned v_total(timing_t t);
    return t.vdisp + t.vfp + t.vpulse + t.vbp;
  endfunction

  // {R,G,B} on/off bits for bars 0..7: white, yellow, cyan, green,
  // magenta, red, blue, black.
  function automatic logic [2:0] bar_rgb(logic [2:0] bar);
    logic [2:0] c;
    case (bar)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing.sv
// Raster counters, run/idle FSM and registered sync/blank/sof outputs.
// Also exposes the raw counter state so the pattern stage can register in step.
module video_timing
  import video_pkg::*;
#(
  parameter timing_t TIM = '{32'd800, 32'd40, 32'd48, 32'd40, 32'd480, 32'd13, 32'd3, 32'd29},
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  localparam int unsigned HTOTAL = h_total(TIM),
  localparam int unsigned VTOTAL = v_total(TIM),
  localparam int HW = $clog2(HTOTAL),
  localparam int VW = $clog2(VTOTAL),
  localparam int XW = $clog2(TIM.hdisp),
  localparam int YW = $clog2(TIM.vdisp)
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst_n,
  input  logic          enable,
  output logic [HW-1:0] hcnt_o,
  output logic [VW-1:0] vcnt_o,
  output logic          active_o,
  output logic          frame_start_o,
  output logic [15:0]   frame_cnt_o,
  output state_e        state_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          blank_o,
  output logic [XW-1:0] pix_x_o,
  output logic [YW-1:0] pix_y_o,
  output logic          sof_o
);

  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          hs_d, vs_d, blank_d, sof_d;
  logic [XW-1:0] pix_x_d;
  logic [YW-1:0] pix_y_d;
  logic [31:0]   hx, vy;
  logic          run, h_last, v_last;

  always_comb begin
    hx      = 32'(hcnt_q);
    vy      = 32'(vcnt_q);
    run     = (state_q == ST_RUN);
    h_last  = (hx == HTOTAL - 1);
    v_last  = (vy == VTOTAL - 1);
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    fcnt_d  = fcnt_q;
    if (!run) begin
      hcnt_d = '0;
      vcnt_d = '0;
      if (enable) state_d = ST_RUN;
    end else if (h_last) begin
      hcnt_d = '0;
      if (v_last) begin
        // Frame boundary: the only place a stop request is honoured.
        vcnt_d = '0;
        fcnt_d = fcnt_q + 16'd1;
        if (!enable) state_d = ST_IDLE;
      end else begin
        vcnt_d = vcnt_q + 1'b1;
      end
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end
    active_o      = run && (hx < TIM.hdisp) && (vy < TIM.vdisp);
    frame_start_o = run && (hcnt_q == '0) && (vcnt_q == '0);
    blank_d       = active_o;
    sof_d         = frame_start_o;
    pix_x_d       = active_o ? XW'(hcnt_q) : '0;
    pix_y_d       = active_o ? YW'(vcnt_q) : '0;
    hs_d = (run && hx >= TIM.hdisp + TIM.hfp &&
            hx < TIM.hdisp + TIM.hfp + TIM.hpulse) ? HS_POL : !HS_POL;
    vs_d = (run && vy >= TIM.vdisp + TIM.vfp &&
            vy < TIM.vdisp + TIM.vfp + TIM.vpulse) ? VS_POL : !VS_POL;
  end

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      fcnt_q  <= '0;
      hs_o    <= !HS_POL;
      vs_o    <= !VS_POL;
      blank_o <= 1'b0;
      pix_x_o <= '0;
      pix_y_o <= '0;
      sof_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      fcnt_q  <= fcnt_d;
      hs_o    <= hs_d;
      vs_o    <= vs_d;
      blank_o <= blank_d;
      pix_x_o <= pix_x_d;
      pix_y_o <= pix_y_d;
      sof_o   <= sof_d;
    end
  end

  assign hcnt_o      = hcnt_q;
  assign vcnt_o      = vcnt_q;
  assign frame_cnt_o = fcnt_q;
  assign state_o     = state_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Raster source with a per-frame latched test-pattern engine.
// Pixel colour is registered alongside the timing outputs so all align.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int PIX_W  = 8
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst_n,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [3*PIX_W-1:0]         solid_rgb,
  output logic                       video_hs,
  output logic                       video_vs,
  output logic                       video_blank,
  output logic [3*PIX_W-1:0]         video_rgb,
  output logic [$clog2(HDISP)-1:0]   pix_x,
  output logic [$clog2(VDISP)-1:0]   pix_y,
  output logic                       sof,
  output logic [15:0]                frame_cnt,
  output logic                       running
);

  localparam timing_t TIM = '{hdisp: 32'(HDISP), hfp: 32'(HFP), hpulse: 32'(HPULSE),
                              hbp: 32'(HBP), vdisp: 32'(VDISP), vfp: 32'(VFP),
                              vpulse: 32'(VPULSE), vbp: 32'(VBP)};
  localparam int HW = $clog2(h_total(TIM));
  localparam int VW = $clog2(v_total(TIM));
  localparam int unsigned BW = HDISP / 8;

  logic [HW-1:0]      hcnt;
  logic [VW-1:0]      vcnt;
  logic               active, frame_start;
  state_e             state;
  pattern_e           mode_q, pat;
  logic [3*PIX_W-1:0] solid_q, solid_cur, pix, rgb_q, rgb_d;
  logic [2:0]         bar, bar_c;
  logic               chk;

  video_timing #(.TIM(TIM), .HS_POL(HS_POL), .VS_POL(VS_POL)) u_timing (
    .pixel_clk     (pixel_clk),
    .pixel_rst_n   (pixel_rst_n),
    .enable        (enable),
    .hcnt_o        (hcnt),
    .vcnt_o        (vcnt),
    .active_o      (active),
    .frame_start_o (frame_start),
    .frame_cnt_o   (frame_cnt),
    .state_o       (state),
    .hs_o          (video_hs),
    .vs_o          (video_vs),
    .blank_o       (video_blank),
    .pix_x_o       (pix_x),
    .pix_y_o       (pix_y),
    .sof_o         (sof)
  );

  always_comb begin
    // Pixel (0,0) already uses the newly sampled inputs.
    pat       = frame_start ? pattern_e'(mode) : mode_q;
    solid_cur = frame_start ? solid_rgb : solid_q;
    bar = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (32'(hcnt) >= k * BW) bar = 3'(k);
    end
    bar_c = bar_rgb(bar);
    chk   = (((32'(hcnt) ^ 32'(vcnt) ^ (32'(frame_cnt) << 4)) & 32'h10) != 32'h0);
    case (pat)
      PAT_SOLID: pix = solid_cur;
      PAT_BARS:  pix = {{PIX_W{bar_c[2]}}, {PIX_W{bar_c[1]}}, {PIX_W{bar_c[0]}}};
      PAT_CHECK: pix = {3*PIX_W{chk}};
      default:   pix = {PIX_W'(hcnt), PIX_W'(vcnt), PIX_W'(frame_cnt)};
    endcase
    rgb_d = active ? pix : '0;
  end

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      rgb_q   <= '0;
      mode_q  <= PAT_SOLID;
      solid_q <= '0;
    end else begin
      rgb_q <= rgb_d;
      if (frame_start) begin
        mode_q  <= pattern_e'(mode);
        solid_q <= solid_rgb;
      end
    end
  end

  assign video_rgb = rgb_q;
  assign running   = (state == ST_RUN);

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen at a tiny 16x4 raster: a frame-position model
// predicts every output cycle, a monitor pops and compares on the falling edge.
module tb_video_pattern_gen;

  localparam int HDISP = 16, VDISP = 4, HFP = 2, HPULSE = 3, HBP = 1;
  localparam int VFP = 1, VPULSE = 1, VBP = 1, PIX_W = 8;
  localparam int HT = HDISP + HFP + HPULSE + HBP;
  localparam int VT = VDISP + VFP + VPULSE + VBP;
  localparam int W = 51;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic        video_hs, video_vs, video_blank, sof, running;
  logic [23:0] video_rgb;
  logic [3:0]  pix_x;
  logic [1:0]  pix_y;
  logic [15:0] frame_cnt;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_W(PIX_W)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .enable(enable), .mode(mode),
    .solid_rgb(solid_rgb), .video_hs(video_hs), .video_vs(video_vs),
    .video_blank(video_blank), .video_rgb(video_rgb), .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .frame_cnt(frame_cnt), .running(running)
  );

  // clock / reset
  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [W-1:0] pack(bit hs, bit vs, bit de, logic [23:0] rgb,
                                        int x, int y, bit s, int fc, bit run);
    return {hs, vs, de, rgb, 4'(x), 2'(y), s, 16'(fc), run};
  endfunction

  function automatic logic [23:0] pattern(int md, logic [23:0] sol, int x, int y, int fc);
    int bar;
    case (md)
      0: return sol;
      1: begin
        bar = x / (HDISP / 8);
        if (bar > 7) bar = 7;
        return bars[bar];
      end
      2: return (((x / 16) + (y / 16) + fc) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      default: return {8'(x % 256), 8'(y % 256), 8'(fc % 256)};
    endcase
  endfunction

  // reference model: position within the frame, advanced once per clock
  initial begin : model
    bit          m_run;
    int          m_pos, m_fc, m_mode, h, v;
    logic [23:0] m_solid, rgb;
    bit          a, hs_e, vs_e, sof_e;
    m_run = 0; m_pos = 0; m_fc = 0; m_mode = 0; m_solid = 0;
    forever begin
      @(posedge pixel_clk);
      if (!pixel_rst_n) begin
        m_run = 0; m_pos = 0; m_fc = 0;
        exp_q.push_back(pack(1, 1, 0, 24'h0, 0, 0, 0, 0, 0));
      end else if (!m_run) begin
        if (enable) begin
          m_run = 1;
          m_pos = 0;
        end
        exp_q.push_back(pack(1, 1, 0, 24'h0, 0, 0, 0, m_fc, m_run));
      end else begin
        h = m_pos % HT;
        v = m_pos / HT;
        if (m_pos == 0) begin
          m_mode  = int'(mode);
          m_solid = solid_rgb;
        end
        a     = (h < HDISP) && (v < VDISP);
        rgb   = a ? pattern(m_mode, m_solid, h, v, m_fc) : 24'h0;
        hs_e  = !(h >= HDISP + HFP && h < HDISP + HFP + HPULSE);
        vs_e  = !(v >= VDISP + VFP && v < VDISP + VFP + VPULSE);
        sof_e = (m_pos == 0);
        m_pos++;
        if (m_pos == HT * VT) begin
          m_pos = 0;
          m_fc  = (m_fc + 1) % 65536;
          if (!enable) m_run = 0;
        end
        exp_q.push_back(pack(hs_e, vs_e, a, rgb, a ? h : 0, a ? v : 0, sof_e, m_fc, m_run));
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic [W-1:0] act, e;
    forever begin
      @(negedge pixel_clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {video_hs, video_vs, video_blank, video_rgb, pix_x, pix_y, sof, frame_cnt, running};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL video_out t=%0t actual=%h required=%h (hs,vs,de,rgb,x,y,sof,fc,run)",
                   $time, act, e);
        end
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic wait_sof();
    int n = 0;
    while (n < 400) begin
      @(negedge pixel_clk);
      if (sof === 1'b1) break;
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL sof_timeout actual=no_sof required=sof_within_400_cycles");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 400) begin
      @(negedge pixel_clk);
      if (running === 1'b0) break;
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL idle_timeout actual=running required=stopped_within_400_cycles");
    end
  endtask

  initial begin : stimulus
    cycles(3);
    pixel_rst_n = 1'b1;
    cycles(2);
    // solid colour frame
    mode = 2'd0; solid_rgb = 24'h123456; enable = 1'b1;
    wait_sof();
    // bars next frame, then two checkerboard frames
    mode = 2'd1;
    wait_sof();
    mode = 2'd2;
    wait_sof();
    wait_sof();
    // mid-frame switch to ramp only lands on the following frame
    mode = 2'd0; solid_rgb = 24'($urandom);
    wait_sof();
    cycles(2 * HT + 5);
    mode = 2'd3;
    wait_sof();
    // random pattern changes at random points
    repeat (6) begin
      mode      = 2'($urandom_range(0, 3));
      solid_rgb = 24'($urandom);
      cycles($urandom_range(1, HT * VT - 1));
    end
    // stop request mid-frame completes the frame
    wait_sof();
    cycles(2 * HT);
    enable = 1'b0;
    wait_idle();
    cycles(10);
    // reset mid-run abandons the frame
    repeat (4) begin
      enable = 1'b1;
      mode   = 2'($urandom_range(0, 3));
      cycles($urandom_range(30, 300));
      pixel_rst_n = 1'b0;
      cycles($urandom_range(1, 3));
      pixel_rst_n = 1'b1;
    end
    // random enable toggling
    repeat (8) begin
      enable    = 1'($urandom_range(0, 1));
      mode      = 2'($urandom_range(0, 3));
      solid_rgb = 24'($urandom);
      cycles($urandom_range(1, 300));
    end
    enable = 1'b0;
    wait_idle();
    cycles(3);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
